// File: rtl/score_counter_if.sv
// Signal bundle between the game controller and score_counter: control pulses and digit
// read-out in, BCD score/status out. CONV sets the low bit index of i_hpos.
interface score_counter_if #(
  parameter int CONV = 0
);
  logic            i_frame_tick;
  logic            i_start;
  logic            i_game_over;
  logic [1:0]      i_digit_sel;
  logic [9:CONV]   i_hpos;
  logic [3:0]      o_num;
  logic            o_blank;
  logic [15:0]     o_score;
  logic [15:0]     o_hi_score;
  logic            o_milestone;
  logic            o_running;

  modport master (
    output i_frame_tick, i_start, i_game_over, i_digit_sel, i_hpos,
    input  o_num, o_blank, o_score, o_hi_score, o_milestone, o_running
  );

  modport slave (
    input  i_frame_tick, i_start, i_game_over, i_digit_sel, i_hpos,
    output o_num, o_blank, o_score, o_hi_score, o_milestone, o_running
  );
endinterface

// File: rtl/score_counter.sv
// Four-digit BCD run score with frame-tick prescaler, saturation at 9999, hundred
// milestones and registered digit read-out. Define SCORE_HISCORE_EN for the best-score register.
module score_counter #(
  parameter int CONV     = 0,
  parameter int TICK_DIV = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  score_counter_if.slave bus
);

  if (TICK_DIV < 1 || TICK_DIV > 63 || CONV < 0 || CONV > 9) begin : g_param_check
    $error("score_counter: TICK_DIV must be 1..63 and CONV 0..9");
  end

  localparam logic [5:0] PRE_LAST = 6'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e      state_q;
  logic [5:0]  pre_q;
  logic [15:0] score_q;
  logic [3:0]  num_q;
  logic        blank_q;
  logic        mile_q;
  logic        run_q;

  logic [15:0] score_inc_d;
  logic        score_sat_d;
  logic [3:0]  num_d;
  logic        blank_d;

  // Ripple BCD +1: a digit at 9 wraps to 0 and carries into the next one.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [1:0] s);
    logic [3:0] d;
    case (s)
      2'd0:    d = v[3:0];
      2'd1:    d = v[7:4];
      2'd2:    d = v[11:8];
      default: d = v[15:12];
    endcase
    return d;
  endfunction

  // A digit is a leading zero when it and everything above it are zero; ones always shows.
  function automatic logic blank_of(input logic [15:0] v, input logic [1:0] s);
    logic b;
    case (s)
      2'd0:    b = 1'b0;
      2'd1:    b = (v[15:4] == 12'd0);
      2'd2:    b = (v[15:8] == 8'd0);
      default: b = (v[15:12] == 4'd0);
    endcase
    return b;
  endfunction

  always_comb begin
    score_inc_d = bcd_inc(score_q);
    score_sat_d = (score_q == 16'h9999);
    num_d       = digit_of(score_q, bus.i_digit_sel);
    blank_d     = blank_of(score_q, bus.i_digit_sel);
  end

`ifdef SCORE_HISCORE_EN
  logic [15:0] hi_q;
  assign bus.o_hi_score = hi_q;
`else
  assign bus.o_hi_score = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= 6'd0;
      score_q <= 16'h0000;
      num_q   <= 4'd0;
      blank_q <= 1'b0;
      mile_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef SCORE_HISCORE_EN
      hi_q    <= 16'h0000;
`endif
    end else begin
      num_q   <= num_d;
      blank_q <= blank_d;
      mile_q  <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (bus.i_start) begin
            state_q <= RUN;
            run_q   <= 1'b1;
            pre_q   <= 6'd0;
            score_q <= 16'h0000;
          end
        end
        RUN: begin
          // Game over beats both a same-cycle start and a scoring tick.
          if (bus.i_game_over) begin
            state_q <= OVER;
            run_q   <= 1'b0;
`ifdef SCORE_HISCORE_EN
            // Valid BCD orders the same as plain binary, so a packed compare is digit-wise.
            if (score_q > hi_q) begin
              hi_q <= score_q;
            end
`endif
          end else if (bus.i_frame_tick) begin
            if (pre_q == PRE_LAST) begin
              pre_q <= 6'd0;
              if (!score_sat_d) begin
                score_q <= score_inc_d;
                mile_q  <= (score_inc_d[7:0] == 8'h00);
              end
            end else begin
              pre_q <= pre_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_score     = score_q;
  assign bus.o_num       = num_q;
  assign bus.o_blank     = blank_q;
  assign bus.o_milestone = mile_q;
  assign bus.o_running   = run_q;

endmodule

// File: tb/tb_score_counter.sv
// Scoreboard bench for score_counter: a decimal reference model predicts every cycle's
// outputs, which are queued at drive time and compared after the clock edge.
module tb_score_counter;

  localparam int TD = 6;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  score_counter_if #(.CONV(0)) bus ();

  score_counter #(.CONV(0), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state: m_st 0=IDLE 1=RUN 2=OVER, score kept as a plain integer.
  int m_st;
  int m_pre;
  int m_score;
  int m_hi;

  logic [38:0] exp_q[$];

  task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [38:0] dut_outs();
    return {bus.o_score, bus.o_hi_score, bus.o_num, bus.o_blank, bus.o_milestone, bus.o_running};
  endfunction

  task automatic step(input logic r, input logic t, input logic s, input logic g,
                      input logic [1:0] sel);
    int          e_num;
    logic        e_blank;
    logic        e_mile;
    logic [38:0] got;
    logic [38:0] expv;
    rst_n            = r;
    bus.i_frame_tick = t;
    bus.i_start      = s;
    bus.i_game_over  = g;
    bus.i_digit_sel  = sel;
    bus.i_hpos       = 10'($urandom_range(0, 639));
    e_num   = 0;
    e_blank = 1'b0;
    e_mile  = 1'b0;
    if (!r) begin
      m_st = 0; m_pre = 0; m_score = 0; m_hi = 0;
    end else begin
      e_num   = (m_score / pow10(int'(sel))) % 10;
      e_blank = (sel != 2'd0) && (m_score < pow10(int'(sel)));
      if (m_st == 1) begin
        if (g) begin
          m_st = 2;
          if (HI_EN && m_score > m_hi) m_hi = m_score;
        end else if (t) begin
          if (m_pre == TD - 1) begin
            m_pre = 0;
            if (m_score < 9999) begin
              m_score = m_score + 1;
              e_mile  = (m_score % 100 == 0);
            end
          end else begin
            m_pre = m_pre + 1;
          end
        end
      end else if (s) begin
        m_st = 1; m_score = 0; m_pre = 0;
      end
    end
    exp_q.push_back({to_bcd(m_score), to_bcd(m_hi), 4'(e_num), e_blank, e_mile, (m_st == 1)});
    @(posedge clk);
    #1;
    got = dut_outs();
    if (exp_q.size() == 0) begin
      chk("queue_empty", 39'd1, 39'd0);
    end else begin
      expv = exp_q.pop_front();
      chk("outs", got, expv);
    end
  endtask

  task automatic tick_until(input int target, input bit need_pre_last);
    int guard;
    guard = 0;
    while (!(m_score == target && (!need_pre_last || m_pre == TD - 1)) && guard < 70000) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      guard++;
    end
    if (guard >= 70000) chk("tick_bound", 39'(m_score), 39'(target));
  endtask

  logic [3:0] sel_num_exp [4];
  logic       sel_blk_exp [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    m_st = 0; m_pre = 0; m_score = 0; m_hi = 0;
    sel_num_exp = '{4'd0, 4'd3, 4'd0, 4'd7};
    sel_blk_exp = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    chk("rst_outs", dut_outs(), 39'd0);

    // Start then 12 ticks -> two points
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("score_12tick", 39'(bus.o_score), 39'h0002);
    chk("running", 39'(bus.o_running), 39'd1);

    // Start while running is ignored
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("start_in_run", 39'(bus.o_score), 39'h0002);

    // Mid-run reset at 0123 discards the score, hi stays at its pre-run value
    tick_until(123, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("rst_run_score", 39'(bus.o_score), 39'h0000);
    chk("rst_run_idle", 39'(bus.o_running), 39'd0);
    chk("rst_run_hi", 39'(bus.o_hi_score), 39'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

    // Game over with a scoring tick at 0041
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    tick_until(41, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    chk("go_tick_score", 39'(bus.o_score), 39'h0041);
    chk("go_tick_over", 39'(bus.o_running), 39'd0);
    chk("go_tick_hi", 39'(bus.o_hi_score), HI_EN ? 39'h0041 : 39'h0000);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

    // Digit read-out at 0307
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    tick_until(307, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'(3 - i));
      chk("sel_num", 39'(bus.o_num), 39'(sel_num_exp[i]));
      chk("sel_blank", 39'(bus.o_blank), 39'(sel_blk_exp[i]));
    end

    // Start and game over together in RUN: game over wins
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    chk("start_go_over", 39'(bus.o_running), 39'd0);
    chk("start_go_hi", 39'(bus.o_hi_score), HI_EN ? 39'h0307 : 39'h0000);

    // 0099 -> 0100 milestone
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    tick_until(99, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    chk("ms_score", 39'(bus.o_score), 39'h0100);
    chk("ms_pulse", 39'(bus.o_milestone), 39'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("ms_clear", 39'(bus.o_milestone), 39'd0);

    // Saturation at 9999
    tick_until(9999, 1'b0);
    for (int i = 0; i < TD; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
      chk("sat_score", 39'(bus.o_score), 39'h9999);
      chk("sat_ms", 39'(bus.o_milestone), 39'd0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    chk("sat_hi", 39'(bus.o_hi_score), HI_EN ? 39'h9999 : 39'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 Parameter CONV, default 0: low bit index of i_hpos, matching the render blocks (unused internally; the port is kept for a uniform hookup).
REQ-002 Parameter TICK_DIV, default 6: number of frame ticks per score point, legal range 1..63.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 i_frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-006 i_start  in  1  one-cycle pulse that begins or restarts a run.
REQ-007 i_game_over  in  1  one-cycle pulse on collision.
REQ-008 i_digit_sel  in  2  digit read index: 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands.
REQ-009 i_hpos  in  [9:CONV]  horizontal position, reserved for future column decode.
REQ-010 o_num  out  4  BCD value of the selected digit, fed to the digit renderer's num input.
REQ-011 o_blank  out  1  selected digit is a leading zero.
REQ-012 o_score  out  16  current score as four BCD digits, [15:12] = thousands.
REQ-013 o_hi_score  out  16  best score as four BCD digits.
REQ-014 o_milestone  out  1  one-cycle pulse each time the score crosses a hundred.
REQ-015 o_running  out  1  high while in state RUN.

Function
REQ-016 The block SHALL implement a three-state FSM:
- IDLE: i_start goes to RUN.
- RUN: i_game_over goes to OVER.
- OVER: i_start goes to RUN.
REQ-017 On entry to RUN from either IDLE or OVER, the block SHALL clear o_score and the prescaler to 0.
REQ-018 In RUN, each i_frame_tick SHALL increment a 6-bit prescaler; when the prescaler equals TICK_DIV-1, it SHALL reset to 0 and the score SHALL increment by 1.
REQ-019 The score increment SHALL be pure BCD with a ripple carry across four digits; no digit ever holds a value above 9.
REQ-020 At 9999 the score SHALL saturate: further increments leave it unchanged, with no wrap and no milestone.
REQ-021 o_milestone SHALL pulse in the cycle after an increment that leaves the low two digits at 00.
REQ-022 In IDLE and OVER, the score and prescaler SHALL hold their values; ticks are ignored.
REQ-023 When i_game_over and a score-incrementing tick arrive in the same cycle, i_game_over SHALL win: no increment, state goes to OVER.
REQ-024 i_start in RUN SHALL be ignored; when i_start and i_game_over arrive together in RUN, i_game_over SHALL win.
REQ-025 On the RUN-to-OVER transition, if o_score > o_hi_score (digit-wise BCD compare), o_hi_score SHALL load o_score in that same edge.
REQ-026 o_num and o_blank SHALL be registered with 1-cycle latency from i_digit_sel, which matches the renderer's registered ROM stage.
REQ-027 o_blank SHALL be 1 when the selected digit and every more-significant digit are 0, excluding the ones digit, which is never blank.
REQ-028 o_running SHALL be 1 exactly while the state is RUN.

Reset
REQ-029 While rst_n = 0 at a clock edge, the block SHALL enter IDLE with:
- prescaler = 0, o_score = 0, o_hi_score = 0.
- o_num = 0, o_blank = 0.
- o_milestone = 0, o_running = 0.
REQ-030 A reset asserted mid-run SHALL discard the current score without updating o_hi_score.

Configuration
REQ-031 With macro SCORE_HISCORE_EN defined, the high-score register and compare of REQ-025 SHALL be present.
REQ-032 Without SCORE_HISCORE_EN, o_hi_score SHALL be constant 0, the compare logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Reset, i_start, then 12 frame ticks with TICK_DIV = 6 -> o_score = 0x0002, o_running = 1.
REQ-034 Preload the score to 0x0099, then one scoring tick -> o_score = 0x0100 and o_milestone high for exactly 1 cycle.
REQ-035 Score at 0x9999, then 6 more ticks -> o_score stays 0x9999 and o_milestone stays 0.
REQ-036 i_game_over together with a scoring tick at 0x0041 -> o_score = 0x0041, state OVER, o_hi_score = 0x0041 (with SCORE_HISCORE_EN).
REQ-037 o_score = 0x0307, i_digit_sel stepped 3, 2, 1, 0 -> next-cycle (o_num, o_blank) = (0,1), (3,0), (0,0), (7,0).
REQ-038 rst_n low for one cycle during RUN at 0x0123 -> the next cycle shows IDLE, o_score = 0, o_hi_score unchanged from its pre-run value.
